// File: rtl/axi_incr_rd_beat_filter_pkg.sv
// Shared types and constants for the INCR read-data return path.
package axi_incr_rd_beat_filter_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Per-command control bits. The AXI ID is appended by the top,
    // because its width is a parameter of that module.
    typedef struct packed {
        logic ignore_begin;
        logic ignore_end;
        logic last;
    } tag_ctl_t;

    // Number of beats of a command that survive the padding filter.
    function automatic logic [1:0] kept_beats(tag_ctl_t c, int unsigned burst_len);
        kept_beats = 2'(burst_len) - {1'b0, c.ignore_begin} - {1'b0, c.ignore_end};
    endfunction

endpackage

// File: rtl/axi_incr_rd_beat_filter_fifo.sv
// Synchronous first-word-fall-through FIFO with registered storage.
// Push while full is ignored, even if a pop happens in the same cycle.
module axi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/axi_incr_rd_beat_filter.sv
// INCR read-data return path: pairs MC beats with command tags, drops
// BL8 alignment padding, marks rlast and buffers beats onto the AXI R channel.
module axi_incr_rd_beat_filter
    import axi_incr_rd_beat_filter_pkg::*;
#(
    parameter int C_DATA_WIDTH      = 128,
    parameter int C_ID_WIDTH        = 4,
    parameter int C_MC_BURST_LEN    = 2,
    parameter int C_CMD_FIFO_DEPTH  = 8,
    parameter int C_DATA_FIFO_DEPTH = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cmd_push,
    input  logic                                 cmd_ignore_begin,
    input  logic                                 cmd_ignore_end,
    input  logic                                 cmd_last,
    input  logic [C_ID_WIDTH-1:0]                cmd_id,
    output logic                                 cmd_full,
    output logic [$clog2(C_DATA_FIFO_DEPTH):0]   data_free_cnt,
    input  logic                                 mc_rd_valid,
    input  logic [C_DATA_WIDTH-1:0]              mc_rd_data,
    output logic [C_ID_WIDTH-1:0]                s_rid,
    output logic [C_DATA_WIDTH-1:0]              s_rdata,
    output logic [1:0]                           s_rresp,
    output logic                                 s_rlast,
    output logic                                 s_rvalid,
    input  logic                                 s_rready,
    output logic [1:0]                           err
);
    localparam int CNT_W     = $clog2(C_DATA_FIFO_DEPTH) + 1;
    localparam int CMD_CNT_W = $clog2(C_CMD_FIFO_DEPTH) + 1;
    localparam int OWED_W    = $clog2(C_CMD_FIFO_DEPTH * C_MC_BURST_LEN) + 1;
    localparam int CMP_W     = (CNT_W > OWED_W) ? CNT_W : OWED_W;

    typedef struct packed {
        tag_ctl_t              ctl;
        logic [C_ID_WIDTH-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [C_ID_WIDTH-1:0]   id;
        logic                    last;
        logic [C_DATA_WIDTH-1:0] data;
    } rent_t;

    // Tag FIFO
    tag_t                 tag_wr;
    tag_t                 tag_hd;
    logic                 tag_empty;
    logic                 tag_pop;
    logic [CMD_CNT_W-1:0] tag_cnt_unused;
    logic                 push_ok;

    // R buffer
    rent_t                rb_wr;
    rent_t                rb_rd;
    logic                 rb_full;
    logic                 rb_empty;
    logic [CNT_W-1:0]     rb_cnt;
    logic                 rb_pop;

    // Beat filter
    logic                 idx_q;
    logic                 beat;
    logic                 first_idx;
    logic                 final_idx;
    logic                 pen_idx;
    logic                 keep;
    logic                 kept_last;

    logic [OWED_W-1:0]    owed_q;
    logic [1:0]           err_q;
    logic [CMP_W-1:0]     free_ext;
    logic [CMP_W-1:0]     owed_ext;

    // With single-beat commands there is nothing to pad, so ignore bits are cleared.
    assign tag_wr.ctl.ignore_begin = (C_MC_BURST_LEN == 2) & cmd_ignore_begin;
    assign tag_wr.ctl.ignore_end   = (C_MC_BURST_LEN == 2) & cmd_ignore_end;
    assign tag_wr.ctl.last         = cmd_last;
    assign tag_wr.id               = cmd_id;
    assign push_ok                 = cmd_push & ~cmd_full;

    axi_sync_fifo #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (C_CMD_FIFO_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (cmd_push),
        .wdata_i (tag_wr),
        .pop_i   (tag_pop),
        .rdata_o (tag_hd),
        .full_o  (cmd_full),
        .empty_o (tag_empty),
        .count_o (tag_cnt_unused)
    );

    // A beat is only meaningful when a tag is waiting for it.
    assign beat      = mc_rd_valid & ~tag_empty;
    assign first_idx = (idx_q == 1'b0);
    assign final_idx = (C_MC_BURST_LEN == 1) | (idx_q == 1'b1);
    assign pen_idx   = (C_MC_BURST_LEN == 2) & first_idx;
    assign keep      = beat
                     & ~(first_idx & tag_hd.ctl.ignore_begin)
                     & ~(final_idx & tag_hd.ctl.ignore_end);
    assign kept_last = tag_hd.ctl.last
                     & ((final_idx & ~tag_hd.ctl.ignore_end)
                      | (pen_idx & tag_hd.ctl.ignore_end));
    assign tag_pop   = beat & final_idx;

    assign rb_wr.id   = tag_hd.id;
    assign rb_wr.last = kept_last;
    assign rb_wr.data = mc_rd_data;
    assign rb_pop     = ~rb_empty & s_rready;

    axi_sync_fifo #(
        .WIDTH ($bits(rent_t)),
        .DEPTH (C_DATA_FIFO_DEPTH)
    ) u_rbuf (
        .clk     (clk),
        .reset   (reset),
        .push_i  (keep),
        .wdata_i (rb_wr),
        .pop_i   (rb_pop),
        .rdata_o (rb_rd),
        .full_o  (rb_full),
        .empty_o (rb_empty),
        .count_o (rb_cnt)
    );

    // Beat index within the current command; stalls while no tag is queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= 1'b0;
        end else if (beat) begin
            idx_q <= final_idx ? 1'b0 : ~idx_q;
        end
    end

    // Beats promised to queued tags but not yet written into the R buffer.
    // Decremented per kept beat even if the buffer drops it, so the count
    // stays tied to tag consumption.
    always_ff @(posedge clk) begin
        if (reset) begin
            owed_q <= '0;
        end else begin
            owed_q <= owed_q
                    + OWED_W'(push_ok ? kept_beats(tag_wr.ctl, C_MC_BURST_LEN) : 2'd0)
                    - OWED_W'(keep);
        end
    end

    // Sticky error flags: [0] tag or beat overflow, [1] beat arrived with no tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 2'b00;
        end else begin
            err_q[0] <= err_q[0] | (cmd_push & cmd_full) | (keep & rb_full);
            err_q[1] <= err_q[1] | (mc_rd_valid & tag_empty);
        end
    end

    // Credit seen by the splitter: free buffer slots not already promised.
    // Clamped at zero so an over-issue cannot wrap into a large credit.
    always_comb begin
        free_ext = CMP_W'(C_DATA_FIFO_DEPTH) - CMP_W'(rb_cnt);
        owed_ext = CMP_W'(owed_q);
        if (owed_ext >= free_ext) data_free_cnt = '0;
        else                      data_free_cnt = CNT_W'(free_ext - owed_ext);
    end

    assign err      = err_q;
    assign s_rvalid = ~rb_empty;
    assign s_rdata  = rb_rd.data;
    assign s_rresp  = RESP_OKAY;
    assign s_rlast  = s_rvalid & rb_rd.last;
    assign s_rid    = s_rvalid ? rb_rd.id : '0;

endmodule

// File: tb/tb_axi_incr_rd_beat_filter.sv
// Directed bench for the INCR read-data beat filter.
module tb_axi_incr_rd_beat_filter;
    localparam int DW = 128;
    localparam int IW = 4;
    localparam int EW = IW + 1 + DW;

    logic           clk = 1'b0;
    logic           reset;
    logic           cmd_push, cmd_ignore_begin, cmd_ignore_end, cmd_last;
    logic [IW-1:0]  cmd_id;
    logic           cmd_full;
    logic [5:0]     data_free_cnt;
    logic           mc_rd_valid;
    logic [DW-1:0]  mc_rd_data;
    logic [IW-1:0]  s_rid;
    logic [DW-1:0]  s_rdata;
    logic [1:0]     s_rresp;
    logic           s_rlast, s_rvalid, s_rready;
    logic [1:0]     err;

    int n_chk = 0;
    int n_bad = 0;
    logic [EW-1:0] got_q[$];
    logic [EW-1:0] exp_q[$];

    axi_incr_rd_beat_filter #(
        .C_DATA_WIDTH(DW), .C_ID_WIDTH(IW), .C_MC_BURST_LEN(2),
        .C_CMD_FIFO_DEPTH(8), .C_DATA_FIFO_DEPTH(32)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_push(cmd_push), .cmd_ignore_begin(cmd_ignore_begin),
        .cmd_ignore_end(cmd_ignore_end), .cmd_last(cmd_last), .cmd_id(cmd_id),
        .cmd_full(cmd_full), .data_free_cnt(data_free_cnt),
        .mc_rd_valid(mc_rd_valid), .mc_rd_data(mc_rd_data),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .err(err)
    );

    always #5 clk = ~clk;

    // Record every beat that will handshake on the coming rising edge.
    always @(negedge clk) begin
        if (!reset && s_rvalid && s_rready) got_q.push_back({s_rid, s_rlast, s_rdata});
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [DW-1:0] dat(input int k);
        logic [DW-1:0] base;
        base = 128'hD000_0000_0000_0000_0000_0000_0000_0000;
        return base | DW'(k);
    endfunction

    task automatic push_tag(input logic ib, input logic ie, input logic last, input logic [IW-1:0] id);
        cmd_push = 1'b1; cmd_ignore_begin = ib; cmd_ignore_end = ie; cmd_last = last; cmd_id = id;
        tick();
        cmd_push = 1'b0; cmd_ignore_begin = 1'b0; cmd_ignore_end = 1'b0; cmd_last = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        mc_rd_valid = 1'b1; mc_rd_data = d;
        tick();
        mc_rd_valid = 1'b0;
    endtask

    task automatic expect_beat(input logic [IW-1:0] id, input logic last, input logic [DW-1:0] d);
        exp_q.push_back({id, last, d});
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_count"}, 256'(got_q.size()), 256'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 256'(got_q[i]), 256'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_push = 1'b0; cmd_ignore_begin = 1'b0; cmd_ignore_end = 1'b0;
        cmd_last = 1'b0; cmd_id = '0; mc_rd_valid = 1'b0; mc_rd_data = '0; s_rready = 1'b1;
        tick(3);
        reset = 1'b0;
        tick();

        chk("rst_rvalid", s_rvalid, 1'b0);
        chk("rst_rlast", s_rlast, 1'b0);
        chk("rst_rid", s_rid, 4'd0);
        chk("rst_cmd_full", cmd_full, 1'b0);
        chk("rst_free", data_free_cnt, 6'd32);
        chk("rst_err", err, 2'b00);

        // Aligned BL2, two commands, four beats.
        push_tag(1'b0, 1'b0, 1'b0, 4'd3);
        push_tag(1'b0, 1'b0, 1'b1, 4'd3);
        chk("t1_free_after_push", data_free_cnt, 6'd28);
        send_beat(dat(0));
        chk("t1_latency_rvalid", s_rvalid, 1'b1);
        chk("t1_latency_rdata", s_rdata, dat(0));
        chk("t1_rresp", s_rresp, 2'b00);
        send_beat(dat(1));
        send_beat(dat(2));
        send_beat(dat(3));
        tick(3);
        expect_beat(4'd3, 1'b0, dat(0));
        expect_beat(4'd3, 1'b0, dat(1));
        expect_beat(4'd3, 1'b0, dat(2));
        expect_beat(4'd3, 1'b1, dat(3));
        cmp_q("t1");
        chk("t1_free_idle", data_free_cnt, 6'd32);
        chk("t1_rlast_idle", s_rlast, 1'b0);

        // axlen=0 with leading pad: one surviving beat, rlast set.
        push_tag(1'b1, 1'b0, 1'b1, 4'd5);
        chk("t2_free", data_free_cnt, 6'd31);
        send_beat(128'hDEAD);
        send_beat(dat(10));
        tick(3);
        expect_beat(4'd5, 1'b1, dat(10));
        cmp_q("t2");

        // axlen=1 with offset: pad, D0, D1, pad.
        push_tag(1'b1, 1'b0, 1'b0, 4'd6);
        push_tag(1'b0, 1'b1, 1'b1, 4'd6);
        chk("t3_free", data_free_cnt, 6'd30);
        send_beat(128'hDEAD);
        send_beat(dat(20));
        send_beat(dat(21));
        send_beat(128'hBEEF);
        tick(3);
        expect_beat(4'd6, 1'b0, dat(20));
        expect_beat(4'd6, 1'b1, dat(21));
        cmp_q("t3");
        chk("t3_free_idle", data_free_cnt, 6'd32);

        // Backpressure: fill all 32 entries, hold, then drain.
        s_rready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            push_tag(1'b0, 1'b0, k[0], 4'(k));
            if (k == 0) chk("t4_free_first_tag", data_free_cnt, 6'd30);
            send_beat(dat(100 + 2*k));
            send_beat(dat(101 + 2*k));
            expect_beat(4'(k), 1'b0, dat(100 + 2*k));
            expect_beat(4'(k), k[0], dat(101 + 2*k));
        end
        tick(2);
        chk("t4_free_full", data_free_cnt, 6'd0);
        chk("t4_rvalid_held", s_rvalid, 1'b1);
        chk("t4_rdata_head", s_rdata, dat(100));
        tick(4);
        chk("t4_rvalid_stable", s_rvalid, 1'b1);
        chk("t4_rdata_stable", s_rdata, dat(100));
        chk("t4_rid_stable", s_rid, 4'd0);
        chk("t4_err_none", err, 2'b00);
        s_rready = 1'b1;
        tick(40);
        cmp_q("t4");
        chk("t4_free_drained", data_free_cnt, 6'd32);
        chk("t4_rvalid_drained", s_rvalid, 1'b0);

        // Beat with no tag queued.
        send_beat(dat(200));
        tick(2);
        chk("t5_err_no_tag", err, 2'b10);
        chk("t5_no_rbeat", s_rvalid, 1'b0);
        cmp_q("t5a");
        // Tag FIFO overflow on the ninth push.
        for (int k = 0; k < 8; k++) push_tag(1'b0, 1'b0, 1'b0, 4'd1);
        chk("t5_cmd_full", cmd_full, 1'b1);
        chk("t5_err_before_ovf", err, 2'b10);
        push_tag(1'b0, 1'b0, 1'b0, 4'd1);
        chk("t5_err_ovf", err, 2'b11);
        chk("t5_free", data_free_cnt, 6'd16);
        do_reset();
        chk("t5_err_cleared", err, 2'b00);
        chk("t5_cmd_full_cleared", cmd_full, 1'b0);

        // Reset mid-burst after 3 of 8 beats.
        s_rready = 1'b0;
        for (int k = 0; k < 4; k++) push_tag(1'b0, 1'b0, k == 3, 4'd7);
        send_beat(dat(300));
        send_beat(dat(301));
        send_beat(dat(302));
        chk("t6_free_mid", data_free_cnt, 6'd24);
        chk("t6_rvalid_mid", s_rvalid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rvalid_after_rst", s_rvalid, 1'b0);
        chk("t6_free_after_rst", data_free_cnt, 6'd32);
        chk("t6_err_after_rst", err, 2'b00);
        s_rready = 1'b1;
        push_tag(1'b0, 1'b0, 1'b0, 4'd9);
        push_tag(1'b0, 1'b0, 1'b1, 4'd9);
        for (int k = 0; k < 4; k++) send_beat(dat(400 + k));
        tick(3);
        for (int k = 0; k < 4; k++) expect_beat(4'd9, k == 3, dat(400 + k));
        cmp_q("t6");
        chk("t6_err_final", err, 2'b00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
